// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - FIFO read-side byte packer
//
// Purpose: reads WIDTH-bit entries from a synchronous FIFO (one-cycle read
// latency) and packs LANES of them into one output word. A flush pulse
// emits a partially filled word. The FIFO is never read while a word waits.
//
// Ports:
//   rd_clk    - sole clock, rising edge
//   res       - asynchronous active-low reset
//   empty     - FIFO empty flag
//   rdata     - FIFO read data, valid the cycle after a granted read
//   rd_en     - FIFO read request (combinational)
//   flush     - single-cycle request to emit a partial word
//   out_data  - packed word, byte k at [k*WIDTH +: WIDTH]
//   out_bytes - number of valid bytes in out_data
//   out_valid - out_data/out_bytes valid
//   out_ready - consumer accept
//   words_out - saturating count of accepted words

module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic                   rd_clk,
  input  logic                   res,
  input  logic                   empty,
  input  logic [WIDTH-1:0]       rdata,
  output logic                   rd_en,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [CNT_W-1:0]       out_bytes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            words_out
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LANES - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rd_pend;
  logic              r_flush_pend;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  r_cap_cnt;
  logic [CNT_W-1:0]  r_out_bytes;
  logic [CNT_W-1:0]  w_out_bytes_nxt;
  logic [WIDTH-1:0]  r_lanes [LANES];
  logic [15:0]       r_words_out;
  logic              w_rd_en;
  logic              w_hs;
  logic              w_flush_clr;

  // Next-state / control. A word is complete either when the capture that
  // fills the last lane lands, or when a pending flush sees no byte in flight.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_bytes_nxt = r_out_bytes;
    w_flush_clr     = 1'b0;
    // Gated by res so the request is low while reset is held.
    w_rd_en = res && (r_state == S_FILL) && !empty && !r_flush_pend &&
              (r_req_cnt < LP_FULL);
    w_hs    = (r_state == S_OUT) && out_ready;
    case (r_state)
      S_FILL: begin
        if (r_rd_pend && (r_cap_cnt == LP_LAST)) begin
          w_state_nxt     = S_OUT;
          w_out_bytes_nxt = LP_FULL;
        end else if (r_flush_pend && !r_rd_pend) begin
          if (r_cap_cnt != '0) begin
            w_state_nxt     = S_OUT;
            w_out_bytes_nxt = r_cap_cnt;
          end else begin
            w_flush_clr = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt     = S_FILL;
          w_out_bytes_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = S_FILL;
        w_out_bytes_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge res) begin
    if (!res) begin
      r_state     <= S_FILL;
      r_out_bytes <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_bytes <= w_out_bytes_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge res) begin
    if (!res) begin
      r_rd_pend    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_req_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_words_out  <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_lanes[k] <= '0;
      end
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_hs) begin
        // Lanes are zeroed here so a later flushed word has zero fill.
        for (int k = 0; k < LANES; k++) begin
          r_lanes[k] <= '0;
        end
        r_req_cnt    <= '0;
        r_cap_cnt    <= '0;
        r_flush_pend <= 1'b0;
        if (r_words_out != 16'hFFFF) begin
          r_words_out <= r_words_out + 16'd1;
        end
      end else begin
        if (w_rd_en) begin
          r_req_cnt <= r_req_cnt + 1'b1;
        end
        if (r_rd_pend) begin
          r_lanes[r_cap_cnt[IDX_W-1:0]] <= rdata;
          r_cap_cnt                     <= r_cap_cnt + 1'b1;
        end
        // A new flush wins over clearing a stale one in the same cycle.
        if ((r_state == S_FILL) && flush) begin
          r_flush_pend <= 1'b1;
        end else if (w_flush_clr) begin
          r_flush_pend <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      out_data[k*WIDTH +: WIDTH] = r_lanes[k];
    end
  end

  assign rd_en     = w_rd_en;
  assign out_valid = (r_state == S_OUT);
  assign out_bytes = r_out_bytes;
  assign words_out = r_words_out;

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning byte width of the FIFO read data.
REQ-002 The block SHALL have parameter LANES, default 4, meaning bytes packed per output word (power of two, >=2).
REQ-003 The block SHALL have parameter CNT_W = $clog2(LANES)+1, meaning the width of byte counters and out_bytes.
REQ-004 rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 res  input  1  reset, asynchronous, active-low (res=0 resets).
REQ-006 empty  input  1  FIFO empty flag, same rd_clk domain.
REQ-007 rdata  input  WIDTH  FIFO read data, valid the cycle after a rd_en=1 && empty=0 edge.
REQ-008 rd_en  output  1  FIFO read request, combinational.
REQ-009 flush  input  1  single-cycle request to emit a partially filled word.
REQ-010 out_data  output  WIDTH*LANES  packed word; byte k in bits [k*WIDTH +: WIDTH].
REQ-011 out_bytes  output  CNT_W  number of valid bytes in out_data (1..LANES).
REQ-012 out_valid  output  1  out_data/out_bytes valid.
REQ-013 out_ready  input  1  consumer accepts word when out_valid && out_ready at a rising edge.
REQ-014 words_out  output  16  count of accepted words, saturating at 16'hFFFF.

Function
REQ-015 The block SHALL implement two states: FILL and OUT.
REQ-016 rd_en SHALL equal (state==FILL) && !empty && !flush_pend && (req_cnt < LANES).
REQ-017 req_cnt SHALL increment at every edge where rd_en=1; rd_pend SHALL register rd_en (one-cycle read latency).
REQ-018 At an edge with rd_pend=1, the block SHALL write rdata into lane cap_cnt and increment cap_cnt; back-to-back requests SHALL sustain one byte per cycle.
REQ-019 When the capture making cap_cnt==LANES occurs, the block SHALL enter OUT next cycle with out_valid=1, out_bytes=LANES.
REQ-020 A flush=1 sample in FILL SHALL set flush_pend, blocking new requests; in-flight rd_pend byte SHALL still be captured.
REQ-021 With flush_pend=1 and rd_pend=0: cap_cnt>0 -> enter OUT with out_bytes=cap_cnt, unfilled lanes zero; cap_cnt==0 -> clear flush_pend, stay FILL.
REQ-022 flush sampled while in OUT SHALL be ignored.
REQ-023 In OUT, out_data, out_bytes, out_valid SHALL hold stable until out_valid && out_ready.
REQ-024 On handshake, the block SHALL clear lanes, req_cnt, cap_cnt, flush_pend, deassert out_valid, return to FILL, and increment words_out unless at 16'hFFFF.
REQ-025 rd_en SHALL be 0 throughout OUT; the FIFO is never read while a word awaits acceptance.
REQ-026 The block SHALL never assert rd_en while empty=1, so it never causes FIFO underflow.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 res=0 SHALL asynchronously force state=FILL, rd_pend=0, req_cnt=0, cap_cnt=0, flush_pend=0, lanes=0.
REQ-029 During reset, outputs SHALL be out_valid=0, out_data=0, out_bytes=0, words_out=0, rd_en=0.
REQ-030 Reset mid-word SHALL discard partially captured bytes; an in-flight FIFO byte is dropped.
REQ-031 After res rises, the first request SHALL occur no earlier than the first rising edge of rd_clk.

Verification
REQ-032 FIFO holds 11,22,33,44, out_ready=1 -> 4 consecutive rd_en cycles, out_data=32'h44332211, out_bytes=4, words_out=1.
REQ-033 FIFO holds 8 bytes, out_ready=0 for 10 cycles -> first word held stable, rd_en=0 during OUT, second word follows after ready.
REQ-034 FIFO holds AA,BB then empty, flush pulse -> out_data=32'h0000BBAA, out_bytes=2.
REQ-035 flush with cap_cnt=0 and empty=1 -> no output, state stays FILL, flush_pend clears.
REQ-036 res=0 asserted after 3 bytes captured -> out_valid=0, counters 0 immediately; next 4 bytes form a fresh word.
REQ-037 Random empty toggling vs reference model -> no rd_en while empty, byte order preserved, words_out matches handshakes.
